cdc_rx_buffer: RTL and testbench
================================

CDC_RX_BUFFER -- requirements
Module: cdc_rx_buffer

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 32 and SHALL set the multibit data width.
REQ-003 Parameter DEPTH SHALL default to 4 and SHALL set the FIFO entry count; only powers of 2 of at least 2 are legal.
REQ-004 Parameter CNT_W SHALL default to 8 and SHALL set the drop-counter width.
REQ-005 Port clk_b SHALL be an input, 1 bit, carrying the receive-domain clock.
REQ-006 Port rst_b SHALL be an input, 1 bit, carrying the asynchronous active-high reset.
REQ-007 Port en SHALL be an input, 1 bit, acting as the write enable from the receive-side clock gate.
REQ-008 Port vld_in SHALL be an input, 1 bit, carrying the synchronized valid pulse from the synchronizer stage.
REQ-009 Port mdata_in SHALL be an input, WIDTH bits, carrying synchronized multibit data that is qualified by vld_in.
REQ-010 Port sdata_in SHALL be an input, 1 bit, carrying the synchronized single-bit level.
REQ-011 Port out_rdy SHALL be an input, 1 bit, carrying consumer ready.
REQ-012 Port clr_ovf SHALL be an input, 1 bit, requesting a clear of the overflow status.
REQ-013 Port vld_out SHALL be an output, 1 bit, indicating that the FIFO head is valid.
REQ-014 Port mdata_out SHALL be an output, WIDTH bits, carrying the FIFO head data.
REQ-015 Port sdata_pulse SHALL be an output, 1 bit, carrying a one-cycle pulse on each sdata_in rising edge.
REQ-016 Port level SHALL be an output, $clog2(DEPTH)+1 bits, carrying the current occupancy.
REQ-017 Port full SHALL be an output, 1 bit, asserted when occupancy equals DEPTH.
REQ-018 Port ovf SHALL be an output, 1 bit, acting as a sticky flag that a write was dropped.
REQ-019 Port drop_cnt SHALL be an output, CNT_W bits, carrying a saturating count of dropped writes.

Function
REQ-020 A write SHALL occur on a clk_b rising edge when vld_in=1, en=1 and (full=0 or a read occurs on the same edge).
REQ-021 The block SHALL ignore vld_in while en=0; such an ignored write SHALL NOT count as a drop.
REQ-022 A read SHALL occur on a clk_b rising edge when vld_out=1 and out_rdy=1; reads SHALL NOT depend on en.
REQ-023 vld_out SHALL equal (level!=0), and mdata_out SHALL equal the entry at the read pointer; both SHALL be combinational from registered state.
REQ-024 Write-to-output latency SHALL be 1 cycle: data written on edge N SHALL appear on mdata_out with vld_out=1 after edge N when the FIFO was empty.
REQ-025 When a read and a write occur on the same edge, level SHALL be unchanged, including when full=1, in which case the write SHALL be accepted.
REQ-026 A read while vld_out=0 SHALL have no effect, and no underflow SHALL be possible.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 A drop SHALL occur when vld_in=1, en=1, full=1 and no read occurs on that edge.
REQ-029 On a drop, FIFO contents SHALL be unchanged, ovf SHALL be set to 1, and drop_cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-030 clr_ovf=1 SHALL clear ovf to 0 and drop_cnt to 0 on the next edge.
REQ-031 When a drop and clr_ovf coincide, ovf SHALL be 1 and drop_cnt SHALL be 1 after that edge.
REQ-032 sdata_in SHALL be registered into sdata_q every cycle, and sdata_pulse SHALL be registered as sdata_in & ~sdata_q, giving a 1-cycle pulse on the edge after the rising level is sampled.
REQ-033 A level held high SHALL produce exactly one pulse.
REQ-034 sdata_pulse SHALL be independent of en.

Reset
REQ-035 Asserting rst_b SHALL immediately force pointers and level to 0, vld_out=0, full=0, ovf=0, drop_cnt=0, sdata_q=0 and sdata_pulse=0.
REQ-036 Asserting rst_b mid-operation SHALL discard all stored entries.
REQ-037 FIFO storage SHALL require no reset, and mdata_out SHALL be don't-care while vld_out=0.
REQ-038 If sdata_in=1 at reset release, sdata_pulse SHALL assert on the first or second edge after release (exactly one pulse).

Verification
REQ-039 Scenario: with en=1 and out_rdy=0, write 0x11,0x22,0x33,0x44 -> full=1 and level=4; a fifth write of 0x55 -> ovf=1, drop_cnt=1, head=0x11.
REQ-040 Scenario: from full with out_rdy=1, write 0x66 and read on the same edge -> level stays 4 and the read order is 0x22,0x33,0x44,0x66 after the prior 0x11.
REQ-041 Scenario: drive 300 drops with CNT_W=8 -> drop_cnt=255; then clr_ovf together with a drop -> ovf=1 and drop_cnt=1.
REQ-042 Scenario: drive vld_in=1 with en=0 for 3 cycles -> level=0, drop_cnt=0 and vld_out=0.
REQ-043 Scenario: drive sdata_in 0->1 and hold it for 5 cycles -> a single 1-cycle sdata_pulse one edge after sampling; then 1->0->1 -> a second pulse.
REQ-044 Scenario: assert rst_b asynchronously mid-clock with level=3 and ovf=1 -> all outputs go to reset values before the next edge, and the first write after release appears with latency 1.

Source files
------------

// File: rtl/cdc_rx_buffer_if.sv
// Bundles the receive-side handshake, data and status signals of cdc_rx_buffer.
// The master side drives writes, reads and clears; the slave side is the buffer.
interface cdc_rx_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic                     en;
    logic                     vld_in;
    logic [WIDTH-1:0]         mdata_in;
    logic                     sdata_in;
    logic                     out_rdy;
    logic                     clr_ovf;
    logic                     vld_out;
    logic [WIDTH-1:0]         mdata_out;
    logic                     sdata_pulse;
    logic [$clog2(DEPTH):0]   level;
    logic                     full;
    logic                     ovf;
    logic [CNT_W-1:0]         drop_cnt;

    modport master (
        output en, vld_in, mdata_in, sdata_in, out_rdy, clr_ovf,
        input  vld_out, mdata_out, sdata_pulse, level, full, ovf, drop_cnt
    );

    modport slave (
        input  en, vld_in, mdata_in, sdata_in, out_rdy, clr_ovf,
        output vld_out, mdata_out, sdata_pulse, level, full, ovf, drop_cnt
    );
endinterface

// File: rtl/cdc_rx_buffer.sv
// Receive-domain FIFO for synchronized CDC data plus a rising-edge detector on the single-bit level.
// Write-to-head latency 1 cycle; a write into a full FIFO is dropped (sticky ovf, saturating count) unless a read frees the slot on the same edge.
module cdc_rx_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_b,
    input  logic             rst_b,
    cdc_rx_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             sdata_q;
    logic             pulse_q;

    logic full_w, rd_w, wr_w, drop_w;

    assign full_w = (level_q == LVL_FULL);
    assign rd_w   = (level_q != '0) && bus.out_rdy;
    // A simultaneous read frees the slot, so a full FIFO still accepts the write.
    assign wr_w   = bus.vld_in && bus.en && (!full_w || rd_w);
    assign drop_w = bus.vld_in && bus.en && full_w && !rd_w;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (wr_w) wptr_d = wptr_q + PTR_ONE;
        if (rd_w) rptr_d = rptr_q + PTR_ONE;

        case ({wr_w, rd_w})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A drop on the clearing edge wins: it is the first event of the new window.
        if (drop_w) begin
            ovf_d = 1'b1;
            if (bus.clr_ovf)              drop_cnt_d = CNT_ONE;
            else if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
        end else if (bus.clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            sdata_q    <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            sdata_q    <= bus.sdata_in;
            pulse_q    <= bus.sdata_in & ~sdata_q;
        end
    end

    // Storage is left unreset; the head is only meaningful while vld_out is high.
    always_ff @(posedge clk_b) begin
        if (wr_w) mem[wptr_q] <= bus.mdata_in;
    end

    assign bus.vld_out     = (level_q != '0);
    assign bus.mdata_out   = mem[rptr_q];
    assign bus.level       = level_q;
    assign bus.full        = full_w;
    assign bus.ovf         = ovf_q;
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.sdata_pulse = pulse_q;
endmodule

// File: tb/tb_cdc_rx_buffer.sv
// Directed scenarios plus randomized traffic against a queue-based reference model of cdc_rx_buffer.
module tb_cdc_rx_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk_b = 1'b0;
    logic rst_b;
    always #5 clk_b = ~clk_b;

    cdc_rx_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    cdc_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_b (clk_b),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [WIDTH-1:0] mq [$];
    logic m_ovf;
    int   m_cnt;
    logic m_sq;
    logic m_pulse;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_cnt   = 0;
        m_sq    = 1'b0;
        m_pulse = 1'b0;
    endtask

    // Applies one clock edge's worth of behaviour using the inputs present before the edge.
    task automatic model_edge();
        bit rd, fl, drop;
        rd   = (mq.size() != 0) && bus.out_rdy;
        fl   = (mq.size() == DEPTH);
        drop = 1'b0;
        if (rd) void'(mq.pop_front());
        if (bus.vld_in && bus.en) begin
            if (!fl || rd) mq.push_back(bus.mdata_in);
            else           drop = 1'b1;
        end
        if (drop) begin
            m_ovf = 1'b1;
            m_cnt = bus.clr_ovf ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        end else if (bus.clr_ovf) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        m_pulse = bus.sdata_in && !m_sq;
        m_sq    = bus.sdata_in;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk_b);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, 64'(bus.level),   64'(mq.size()));
        check({tag, ".vld"},   64'(bus.vld_out), 64'(mq.size() != 0));
        check({tag, ".full"},  64'(bus.full),    64'(mq.size() == DEPTH));
        check({tag, ".ovf"},   64'(bus.ovf),     64'(m_ovf));
        check({tag, ".cnt"},   64'(bus.drop_cnt), 64'(m_cnt));
        check({tag, ".pulse"}, 64'(bus.sdata_pulse), 64'(m_pulse));
        if (mq.size() != 0) check({tag, ".head"}, 64'(bus.mdata_out), 64'(mq[0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] exp4 [4];
        int pc;

        rst_b = 1'b1;
        bus.en = 1'b0; bus.vld_in = 1'b0; bus.mdata_in = '0; bus.sdata_in = 1'b0;
        bus.out_rdy = 1'b0; bus.clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_b);
        #1;
        rst_b = 1'b0;
        check("rst.level", 64'(bus.level), 64'd0);
        check("rst.vld",   64'(bus.vld_out), 64'd0);
        check("rst.full",  64'(bus.full), 64'd0);
        check("rst.ovf",   64'(bus.ovf), 64'd0);
        check("rst.cnt",   64'(bus.drop_cnt), 64'd0);
        check("rst.pulse", 64'(bus.sdata_pulse), 64'd0);

        // Fill to full, then one dropped write.
        bus.en = 1'b1;
        bus.vld_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.mdata_in = 32'(i * 32'h11);
            cyc();
            check_all("fill");
        end
        check("s1.full",  64'(bus.full), 64'd1);
        check("s1.level", 64'(bus.level), 64'd4);
        bus.mdata_in = 32'h55;
        cyc();
        check("s1.ovf",  64'(bus.ovf), 64'd1);
        check("s1.cnt",  64'(bus.drop_cnt), 64'd1);
        check("s1.head", 64'(bus.mdata_out), 64'h11);

        // Simultaneous read and write while full.
        bus.mdata_in = 32'h66;
        bus.out_rdy  = 1'b1;
        cyc();
        check("s2.level", 64'(bus.level), 64'd4);
        check_all("s2");
        bus.vld_in = 1'b0;
        exp4[0] = 32'h22; exp4[1] = 32'h33; exp4[2] = 32'h44; exp4[3] = 32'h66;
        for (int i = 0; i < 4; i++) begin
            check("s2.order", 64'(bus.mdata_out), 64'(exp4[i]));
            cyc();
        end
        check("s2.empty_level", 64'(bus.level), 64'd0);
        check("s2.empty_vld",   64'(bus.vld_out), 64'd0);
        cyc();
        check_all("s2.underflow");

        // Saturating drop counter and clear-with-drop.
        bus.clr_ovf = 1'b1;
        cyc();
        bus.clr_ovf = 1'b0;
        check("s3.clr_ovf", 64'(bus.ovf), 64'd0);
        check("s3.clr_cnt", 64'(bus.drop_cnt), 64'd0);
        bus.out_rdy = 1'b0;
        bus.vld_in  = 1'b1;
        for (int i = 0; i < 304; i++) begin
            bus.mdata_in = $urandom;
            cyc();
        end
        check("s3.sat_cnt", 64'(bus.drop_cnt), 64'd255);
        check_all("s3.sat");
        bus.clr_ovf = 1'b1;
        cyc();
        check("s3.clrdrop_ovf", 64'(bus.ovf), 64'd1);
        check("s3.clrdrop_cnt", 64'(bus.drop_cnt), 64'd1);
        bus.vld_in = 1'b0;
        cyc();
        bus.clr_ovf = 1'b0;
        check_all("s3.clr");

        // Writes ignored while en is low.
        bus.out_rdy = 1'b1;
        repeat (4) cyc();
        bus.out_rdy = 1'b0;
        bus.en      = 1'b0;
        bus.vld_in  = 1'b1;
        repeat (3) begin
            bus.mdata_in = $urandom;
            cyc();
            check_all("s4");
        end
        check("s4.level", 64'(bus.level), 64'd0);
        check("s4.cnt",   64'(bus.drop_cnt), 64'd0);
        check("s4.vld",   64'(bus.vld_out), 64'd0);

        // Rising-edge pulse on the single-bit level, independent of en.
        bus.vld_in   = 1'b0;
        bus.sdata_in = 1'b1;
        pc = 0;
        repeat (5) begin
            cyc();
            check_all("s5.hold");
            pc += int'(bus.sdata_pulse);
        end
        check("s5.pulses", 64'(pc), 64'd1);
        bus.sdata_in = 1'b0;
        cyc();
        bus.sdata_in = 1'b1;
        cyc();
        check("s5.second", 64'(bus.sdata_pulse), 64'd1);
        cyc();
        check("s5.second_end", 64'(bus.sdata_pulse), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.en       = ($urandom_range(3) != 0);
            bus.vld_in   = $urandom_range(1);
            bus.mdata_in = $urandom;
            bus.out_rdy  = $urandom_range(1);
            bus.clr_ovf  = ($urandom_range(15) == 0);
            bus.sdata_in = $urandom_range(1);
            cyc();
            check_all("rand");
        end

        // Asynchronous reset mid-cycle with level 3 and ovf set.
        bus.clr_ovf = 1'b0;
        bus.vld_in  = 1'b0;
        bus.out_rdy = 1'b1;
        bus.en      = 1'b1;
        repeat (4) cyc();
        bus.out_rdy = 1'b0;
        bus.vld_in  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.mdata_in = 32'(32'hA0 + i);
            cyc();
        end
        bus.vld_in  = 1'b0;
        bus.out_rdy = 1'b1;
        cyc();
        bus.out_rdy = 1'b0;
        check("s6.pre_level", 64'(bus.level), 64'd3);
        check("s6.pre_ovf",   64'(bus.ovf), 64'd1);
        bus.sdata_in = 1'b1;
        #2;
        rst_b = 1'b1;
        model_reset();
        #1;
        check_all("s6.async");
        @(negedge clk_b);
        rst_b = 1'b0;
        bus.vld_in   = 1'b1;
        bus.mdata_in = 32'h77;
        cyc();
        check("s6.lat_vld",  64'(bus.vld_out), 64'd1);
        check("s6.lat_head", 64'(bus.mdata_out), 64'h77);
        check("s6.rel_pulse", 64'(bus.sdata_pulse), 64'd1);
        bus.vld_in = 1'b0;
        cyc();
        check_all("s6.post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
